// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: latches a 6-digit packed BCD result and time-multiplexes it
// onto a common-anode 7-segment bus (active-low an/seg) with decimal point.
// Optional leading-zero blanking is built when BCD_SEG_LZB_EN is defined.
module bcd_seg_scan #(
  parameter int unsigned DWELL = 1,
  parameter int unsigned NDIG  = 6
) (
  input  logic        clk_1k,
  input  logic        Rst,
  input  logic [23:0] data,
  input  logic        upd,
  input  logic [2:0]  dp_sel,
  output logic [5:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NDIG - 1);

  logic [23:0]   sh_data;
  logic [2:0]    sh_dp;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [3:0]    digit;
  logic          dp_hit;
  logic          blank_cur;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles show '-'
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Shadow register: display only changes on an update strobe
  always_ff @(posedge clk_1k) begin
    if (Rst) begin
      sh_data <= 24'd0;
      sh_dp   <= 3'd7;
    end else if (upd) begin
      sh_data <= data;
      sh_dp   <= dp_sel;
    end
  end

`ifdef BCD_SEG_LZB_EN
  logic [5:0] blank;

  // Digit k blanks when it and every digit above it are zero, unless it is
  // digit 0 or lies at/below the decimal point
  function automatic logic [5:0] lzb_mask(input logic [23:0] d, input logic [2:0] dp);
    logic [5:0] m;
    logic       zero_above;
    m          = 6'd0;
    zero_above = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      zero_above = zero_above & (d[4*k +: 4] == 4'd0);
      m[k]       = zero_above & ~((dp <= 3'd5) && (3'(k) <= dp));
    end
    return m;
  endfunction

  // Blank mask is computed from the incoming value and captured with it
  always_ff @(posedge clk_1k) begin
    if (Rst) begin
      blank <= 6'b111110;
    end else if (upd) begin
      blank <= lzb_mask(data, dp_sel);
    end
  end

  assign blank_cur = blank[idx];
`else
  assign blank_cur = 1'b0;
`endif

  // Dwell counter and scan index; index wraps 5 -> 0
  always_ff @(posedge clk_1k) begin
    if (Rst) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign digit  = sh_data[{idx, 2'b00} +: 4];
  assign dp_hit = (idx == sh_dp);

  // Registered drive of the current digit from current index/shadow/mask
  always_ff @(posedge clk_1k) begin
    if (Rst) begin
      an  <= 6'h3F;
      seg <= 8'hFF;
    end else begin
      an  <= ~(6'b000001 << idx);
      seg <= {~dp_hit, blank_cur ? 7'h7F : decode(digit)};
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: two instances (DWELL=1 and DWELL=4) share inputs
// and are compared each cycle against a cycle-count based reference model.
module tb_bcd_seg_scan;

  logic        clk_1k = 1'b0;
  logic        Rst    = 1'b1;
  logic [23:0] data   = 24'd0;
  logic        upd    = 1'b0;
  logic [2:0]  dp_sel = 3'd7;
  logic [5:0]  an1, an4;
  logic [7:0]  seg1, seg4;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: shadow value, dp, and edges since reset release
  logic [23:0] m_data = 24'd0;
  logic [2:0]  m_dp   = 3'd7;
  int          m_n    = 0;

  logic [7:0] got [6];
  logic [7:0] want [6];

  always #5 clk_1k = ~clk_1k;

  bcd_seg_scan #(.DWELL(1), .NDIG(6)) u1 (
    .clk_1k(clk_1k), .Rst(Rst), .data(data), .upd(upd), .dp_sel(dp_sel),
    .an(an1), .seg(seg1)
  );

  bcd_seg_scan #(.DWELL(4), .NDIG(6)) u4 (
    .clk_1k(clk_1k), .Rst(Rst), .data(data), .upd(upd), .dp_sel(dp_sel),
    .an(an4), .seg(seg4)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // Expected display after n edges since reset release for a given dwell
  function automatic void model_out(input int dwell, input logic [23:0] d,
                                    input logic [2:0] dp, input int n,
                                    output logic [5:0] a, output logic [7:0] s);
    int  pos;
    bit  blank;
    logic [23:0] above;
    pos   = (n / dwell) % 6;
    above = d >> (4 * pos);
    blank = 1'b0;
`ifdef BCD_SEG_LZB_EN
    blank = (pos != 0) && !((dp <= 3'd5) && (pos <= int'(dp))) && (above == 24'd0);
`endif
    s = blank ? 8'hFF : seg_of(above[3:0]);
    if (int'(dp) == pos) s[7] = 1'b0;
    a = 6'h3F;
    a[pos] = 1'b0;
  endfunction

  // One clock edge with given inputs; checks both instances against the model
  task automatic tick(input logic r, input logic u, input logic [23:0] d, input logic [2:0] p);
    logic [5:0] ea1, ea4;
    logic [7:0] es1, es4;
    Rst = r; upd = u; data = d; dp_sel = p;
    if (r) begin
      ea1 = 6'h3F; es1 = 8'hFF; ea4 = 6'h3F; es4 = 8'hFF;
    end else begin
      model_out(1, m_data, m_dp, m_n, ea1, es1);
      model_out(4, m_data, m_dp, m_n, ea4, es4);
    end
    @(posedge clk_1k); #1;
    chk("an_d1",  {2'b00, an1}, {2'b00, ea1});
    chk("seg_d1", seg1, es1);
    chk("an_d4",  {2'b00, an4}, {2'b00, ea4});
    chk("seg_d4", seg4, es4);
    if (r) begin
      m_data = 24'd0; m_dp = 3'd7; m_n = 0;
    end else begin
      if (u) begin m_data = d; m_dp = p; end
      m_n++;
    end
  endtask

  // Six idle edges on the DWELL=1 instance, collecting seg per displayed digit
  task automatic capture();
    for (int i = 0; i < 6; i++) got[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 24'h000000, 3'd0);
      for (int k = 0; k < 6; k++) if (an1[k] == 1'b0) got[k] = seg1;
    end
  endtask

  task automatic chk_got(input string tag);
    for (int k = 0; k < 6; k++) chk(tag, got[k], want[k]);
  endtask

  initial begin
    logic [23:0] rd;
    logic [7:0]  lz;
`ifdef BCD_SEG_LZB_EN
    lz = 8'hFF;
`else
    lz = 8'hC0;
`endif

    // Reset held two cycles
    tick(1'b1, 1'b0, 24'h0, 3'd7);
    tick(1'b1, 1'b0, 24'h0, 3'd7);
    chk("rst_an", {2'b00, an1}, 8'h3F);
    chk("rst_seg", seg1, 8'hFF);

    // Scan order after release
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 24'h0, 3'd7);
      rd = 24'h00003F & ~(24'd1 << (i % 6));
      chk("scan_seq", {2'b00, an1}, rd[7:0]);
    end

    // Decode of 012345, no dp
    tick(1'b0, 1'b1, 24'h012345, 3'd7);
    capture();
    want = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, lz};
    chk_got("decode_012345");

    // Invalid nibble with dp on digit 0
    tick(1'b0, 1'b1, 24'h00000A, 3'd0);
    capture();
    chk("invalid_dp", got[0], 8'h3F);

    // Blanking stops at the dp position
    tick(1'b0, 1'b1, 24'h000050, 3'd2);
    capture();
    want = '{8'hC0, 8'h92, 8'h40, lz, lz, lz};
    chk_got("blank_vs_dp");

    // Mid-operation reset while digit 3 is on
    tick(1'b0, 1'b1, 24'h999999, 3'd7);
    for (int i = 0; i < 12 && an1 !== 6'h37; i++) tick(1'b0, 1'b0, 24'h0, 3'd7);
    chk("mid_d3", {2'b00, an1}, 8'h37);
    tick(1'b1, 1'b0, 24'h0, 3'd7);
    chk("mid_rst_an", {2'b00, an1}, 8'h3F);
    capture();
    want = '{8'hC0, lz, lz, lz, lz, lz};
    chk_got("after_mid_rst");

    // Coincident update with index advance 2->3 on the DWELL=4 instance
    tick(1'b1, 1'b0, 24'h0, 3'd7);
    tick(1'b0, 1'b1, 24'h111111, 3'd7);
    for (int i = 0; i < 30 && m_n != 11; i++) tick(1'b0, 1'b0, 24'h0, 3'd7);
    chk("coin_pos", 8'(m_n), 8'd11);
    tick(1'b0, 1'b1, 24'h098765, 3'd7);
    chk("coin_prev_an", {2'b00, an4}, 8'h3B);
    chk("coin_prev_seg", seg4, 8'hF9);
    tick(1'b0, 1'b0, 24'h0, 3'd7);
    chk("coin_an", {2'b00, an4}, 8'h37);
    chk("coin_seg", seg4, 8'h80);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rd = 24'($urandom) & (24'hFFFFFF >> (4 * ($urandom % 6)));
      tick(($urandom % 50) == 0, ($urandom % 5) == 0, rd, 3'($urandom % 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
